// File: rtl/ifetch_mem_ctrl.sv
// Fetch-side instruction memory sequencer: owns the fetch PC, keeps a single read
// outstanding on a req/gnt/rvalid handshake and hands words to decode through a one-entry skid.
module ifetch_mem_ctrl #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              dec_stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] fetch_pc
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
    logic                inst_valid_q, inst_valid_d;
    logic [DATA_W-1:0]   inst_q, inst_d;
    logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
    logic                skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [ADDR_W-1:0]   skid_pc_q, skid_pc_d;

    logic consume;
    logic out_free;
    logic req_issue;

    assign consume   = inst_valid_q && !dec_stall;
    // Output slot is free when empty or when this cycle's consume leaves nothing behind it.
    assign out_free  = !inst_valid_q || (consume && !skid_valid_q);
    assign req_issue = !rst && (state_q == ST_REQ) && !skid_valid_q && !redirect_valid;

    assign mem_req    = req_issue;
    assign mem_addr   = pc_q;
    assign fetch_pc   = pc_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_pc_d    = skid_pc_q;

        if (consume) begin
            if (skid_valid_q) begin
                inst_d       = skid_data_q;
                inst_pc_d    = skid_pc_q;
                skid_valid_d = 1'b0;
            end else begin
                inst_valid_d = 1'b0;
            end
        end

        case (state_q)
            ST_REQ: begin
                if (req_issue && mem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + ADDR_W'(4);
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    if (out_free) begin
                        inst_valid_d = 1'b1;
                        inst_d       = mem_rdata;
                        inst_pc_d    = req_pc_q;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = mem_rdata;
                        skid_pc_d    = req_pc_q;
                    end
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (mem_rvalid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        // Redirect overrides everything above; an outstanding read becomes stale.
        if (redirect_valid) begin
            pc_d         = redirect_pc;
            inst_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            case (state_q)
                ST_REQ:  state_d = ST_REQ;
                ST_WAIT: state_d = mem_rvalid ? ST_REQ : ST_DROP;
                ST_DROP: state_d = ST_DROP;
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Pure data holding registers; their contents only matter when qualified by a valid.
    always_ff @(posedge clk) begin
        req_pc_q    <= req_pc_d;
        skid_data_q <= skid_data_d;
        skid_pc_q   <= skid_pc_d;
    end

endmodule

// File: tb/tb_ifetch_mem_ctrl.sv
// Bench for ifetch_mem_ctrl: cycle table, directed corner sequences, then random
// traffic checked against an in-order queue model of granted fetches.
module tb_ifetch_mem_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] fetch_pc;

    ifetch_mem_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .RESET_PC(RST_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .dec_stall     (dec_stall),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .fetch_pc      (fetch_pc)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] last_gnt = 32'h0;
    logic        busy = 1'b0;

    // Model state for the random phase
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc;
    int          n_cons = 0;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        stall;
        logic        gnt;
        logic        rv;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rp,
                                input logic st, input logic g, input logic v,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_iv, input logic [31:0] e_ipc);
        vec_t t;
        t.rst = r; t.redir = rd; t.rpc = rp; t.stall = st; t.gnt = g; t.rv = v;
        t.e_req = e_req; t.e_addr = e_addr; t.e_iv = e_iv; t.e_ipc = e_ipc;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, return at the following negedge.
    task automatic drive(input logic r, input logic rd, input logic [31:0] rp,
                         input logic st, input logic g, input logic v);
        @(posedge clk);
        #1;
        rst            = r;
        redirect_valid = rd;
        redirect_pc    = rp;
        dec_stall      = st;
        mem_gnt        = g;
        mem_rvalid     = v;
        mem_rdata      = v ? mem_word(last_gnt) : 32'h0BAD_F00D;
        @(negedge clk);
        if (mem_rvalid || rst) busy = 1'b0;
        if (mem_req && mem_gnt) begin
            busy     = 1'b1;
            last_gnt = mem_addr;
        end
    endtask

    // Reference: every granted address is delivered once, in grant order, unless a
    // redirect or reset intervenes; the fetch PC steps by 4 per grant from the last target.
    task automatic model_step();
        logic        cons;
        logic [63:0] e;
        cons = inst_valid && !dec_stall && !rst && !redirect_valid;
        if (rst || redirect_valid) chk("rand req_during_redirect", mem_req, 1'b0);
        chk("rand fetch_pc", fetch_pc, exp_pc);
        if (mem_req) chk("rand mem_addr", mem_addr, exp_pc);
        if (cons) begin
            if (exp_q.size() == 0) begin
                chk("rand spurious_inst_valid", inst_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("rand inst_pc", inst_pc, e[63:32]);
                chk("rand inst", inst, e[31:0]);
                n_cons++;
            end
        end
        if (rst) begin
            exp_q.delete();
            exp_pc = RST_PC;
        end else if (redirect_valid) begin
            exp_q.delete();
            exp_pc = redirect_pc;
        end else if (mem_req && mem_gnt) begin
            exp_q.push_back({exp_pc, mem_word(exp_pc)});
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; dec_stall = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // Reset state
        drive(1, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 1, 0);
        chk("reset mem_req", mem_req, 1'b0);
        chk("reset inst_valid", inst_valid, 1'b0);
        chk("reset inst", inst, 32'h0);
        chk("reset inst_pc", inst_pc, 32'h0);
        chk("reset fetch_pc", fetch_pc, RST_PC);

        //            rst rd rpc          st g  v | req addr          iv ipc
        tbl.push_back(mk(0, 0, 32'h0,     0, 1, 0,  1, 32'h100,  0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,     0, 1, 1,  0, 32'h104,  0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,     0, 1, 0,  1, 32'h104,  1, 32'h100));
        tbl.push_back(mk(0, 0, 32'h0,     0, 1, 1,  0, 32'h108,  0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,     0, 1, 0,  1, 32'h108,  1, 32'h104));
        tbl.push_back(mk(0, 0, 32'h0,     0, 1, 1,  0, 32'h10c,  0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,     1, 1, 0,  1, 32'h10c,  1, 32'h108));
        tbl.push_back(mk(0, 0, 32'h0,     1, 0, 1,  0, 32'h110,  1, 32'h108));
        tbl.push_back(mk(0, 0, 32'h0,     1, 1, 0,  0, 32'h110,  1, 32'h108));
        tbl.push_back(mk(0, 0, 32'h0,     1, 1, 0,  0, 32'h110,  1, 32'h108));
        tbl.push_back(mk(0, 0, 32'h0,     1, 1, 0,  0, 32'h110,  1, 32'h108));
        tbl.push_back(mk(0, 0, 32'h0,     1, 1, 0,  0, 32'h110,  1, 32'h108));
        tbl.push_back(mk(0, 0, 32'h0,     0, 1, 0,  0, 32'h110,  1, 32'h108));
        tbl.push_back(mk(0, 0, 32'h0,     0, 1, 0,  1, 32'h110,  1, 32'h10c));
        tbl.push_back(mk(0, 0, 32'h0,     0, 1, 1,  0, 32'h114,  0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,     0, 1, 0,  1, 32'h114,  1, 32'h110));
        tbl.push_back(mk(0, 1, 32'h2000,  0, 1, 0,  0, 32'h118,  0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,     0, 1, 0,  0, 32'h2000, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,     0, 1, 0,  0, 32'h2000, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,     0, 1, 1,  0, 32'h2000, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,     0, 1, 0,  1, 32'h2000, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,     0, 0, 1,  0, 32'h2004, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,     1, 0, 0,  1, 32'h2004, 1, 32'h2000));
        tbl.push_back(mk(0, 1, 32'h3000,  1, 0, 0,  0, 32'h2004, 1, 32'h2000));
        tbl.push_back(mk(0, 0, 32'h0,     0, 1, 0,  1, 32'h3000, 0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h4000,  0, 1, 1,  0, 32'h3004, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,     0, 0, 0,  1, 32'h4000, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,     0, 1, 0,  1, 32'h4000, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,     0, 0, 1,  0, 32'h4004, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0,     0, 0, 0,  1, 32'h4004, 1, 32'h4000));
        tbl.push_back(mk(0, 0, 32'h0,     0, 0, 0,  1, 32'h4004, 0, 32'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].stall, tbl[i].gnt, tbl[i].rv);
            chk($sformatf("tbl%0d mem_req", i), mem_req, tbl[i].e_req);
            chk($sformatf("tbl%0d mem_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d fetch_pc", i), fetch_pc, tbl[i].e_addr);
            chk($sformatf("tbl%0d inst_valid", i), inst_valid, tbl[i].e_iv);
            if (tbl[i].e_iv) begin
                chk($sformatf("tbl%0d inst_pc", i), inst_pc, tbl[i].e_ipc);
                chk($sformatf("tbl%0d inst", i), inst, mem_word(tbl[i].e_ipc));
            end
        end

        // Redirect while output held and skid full
        drive(0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 1, 0, 1);
        drive(0, 1, 32'h5000, 1, 1, 0);
        chk("skidredir held_pc", inst_pc, 32'h4004);
        chk("skidredir req_blocked", mem_req, 1'b0);
        drive(0, 0, 0, 0, 0, 0);
        chk("skidredir inst_valid_drop", inst_valid, 1'b0);
        chk("skidredir req", mem_req, 1'b1);
        chk("skidredir addr", mem_addr, 32'h5000);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("skidredir first_valid", inst_valid, 1'b1);
        chk("skidredir first_pc", inst_pc, 32'h5000);

        // Address wrap with a delayed grant
        drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk($sformatf("wrap hold%0d req", k), mem_req, 1'b1);
            chk($sformatf("wrap hold%0d addr", k), mem_addr, 32'hFFFF_FFFC);
        end
        drive(0, 0, 0, 0, 1, 0);
        chk("wrap gnt addr", mem_addr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0, 1);
        chk("wrap next fetch_pc", fetch_pc, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        chk("wrap inst_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap next addr", mem_addr, 32'h0);

        // Reset during WAIT, stale response afterwards
        drive(0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 1, 0);
        chk("rstwait req", mem_req, 1'b0);
        drive(1, 0, 0, 0, 1, 0);
        chk("rstwait req2", mem_req, 1'b0);
        chk("rstwait inst_valid", inst_valid, 1'b0);
        chk("rstwait inst", inst, 32'h0);
        chk("rstwait inst_pc", inst_pc, 32'h0);
        drive(0, 0, 0, 0, 0, 1);
        chk("rstwait stale req", mem_req, 1'b1);
        chk("rstwait stale addr", mem_addr, RST_PC);
        drive(0, 0, 0, 0, 0, 0);
        chk("rstwait stale ignored", inst_valid, 1'b0);
        chk("rstwait addr held", mem_addr, RST_PC);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("rstwait first inst_pc", inst_pc, RST_PC);
        chk("rstwait first inst", inst, mem_word(RST_PC));

        // Random traffic against the queue model
        drive(1, 0, 0, 0, 0, 0);
        exp_q.delete();
        exp_pc = RST_PC;
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst, r_red, r_st, r_g, r_v;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 299) == 0);
            r_red = ($urandom_range(0, 9) == 0);
            r_pc  = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            r_st  = ($urandom_range(0, 2) == 0);
            r_g   = 1'($urandom_range(0, 1));
            r_v   = busy && ($urandom_range(0, 1) == 1);
            drive(r_rst, r_red, r_pc, r_st, r_g, r_v);
            model_step();
        end
        for (int c = 0; c < 12; c++) begin
            drive(0, 0, 0, 0, 0, busy);
            model_step();
        end
        chk("drain leftover", 32'(exp_q.size()), 32'h0);
        chk("drain inst_valid", inst_valid, 1'b0);
        chk("rand deliveries", (n_cons > 100) ? 32'h1 : 32'h0, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
